muldiv_arbiter: RTL and testbench

Shares one RV32M multiply/divide unit between two requesters, e.g. the integer execute stage and a second issue slot or a debug/microcode port. Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin. Sequences the unit's START/STALL/READY protocol and returns the result through a tagged, back-pressured response channel. Also handles per-requester flush and a watchdog timeout.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_arbiter_if.sv | 37 +++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/muldiv_arbiter.sv | 149 ++++++++++++++
 tb/tb_muldiv_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M unit arbiter: op codes, FSM states, defaults.
package muldiv_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int MAX_CYCLES_DEFAULT = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_arbiter_if.sv
// Request/response channels of both requesters plus the shared unit's control bus.
// Handshakes: a transfer happens on the rising edge where VALID and READY are both high.
interface muldiv_arbiter_if import muldiv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);

  logic            REQ0_VALID, REQ1_VALID;
  logic [2:0]      REQ0_OP, REQ1_OP;
  logic [XLEN-1:0] REQ0_RS1, REQ0_RS2, REQ1_RS1, REQ1_RS2;
  logic            REQ0_READY, REQ1_READY;
  logic            RSP0_VALID, RSP1_VALID;
  logic [XLEN-1:0] RSP0_DATA, RSP1_DATA;
  logic            RSP0_ERR, RSP1_ERR;
  logic            RSP0_READY, RSP1_READY;
  logic            FLUSH0, FLUSH1;
  logic            MD_START, MD_STALL;
  logic [2:0]      MD_M_CNT;
  logic [XLEN-1:0] MD_RS1, MD_RS2, MD_OUT;
  logic            MD_READY;

  modport slave (
    input  REQ0_VALID, REQ1_VALID, REQ0_OP, REQ1_OP,
           REQ0_RS1, REQ0_RS2, REQ1_RS1, REQ1_RS2,
           RSP0_READY, RSP1_READY, FLUSH0, FLUSH1, MD_OUT, MD_READY,
    output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID,
           RSP0_DATA, RSP1_DATA, RSP0_ERR, RSP1_ERR,
           MD_START, MD_STALL, MD_M_CNT, MD_RS1, MD_RS2
  );

  modport master (
    output REQ0_VALID, REQ1_VALID, REQ0_OP, REQ1_OP,
           REQ0_RS1, REQ0_RS2, REQ1_RS1, REQ1_RS2,
           RSP0_READY, RSP1_READY, FLUSH0, FLUSH1, MD_OUT, MD_READY,
    input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID,
           RSP0_DATA, RSP1_DATA, RSP0_ERR, RSP1_ERR,
           MD_START, MD_STALL, MD_M_CNT, MD_RS1, MD_RS2
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; last_grant only moves when an operation retires.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       upd_id_i,
  output logic [1:0] gnt_o
);

  logic last_grant_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_q <= 1'b1;
    end else if (update_i) begin
      last_grant_q <= upd_id_i;
    end
  end

  // On contention the requester not served last wins; otherwise the lone requester.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_grant_q ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one RV32M mul/div unit between two requesters: grant, launch, watchdog,
// drain and tagged back-pressured response, one operation in flight at a time.
module muldiv_arbiter import muldiv_pkg::*; #(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  muldiv_arbiter_if.slave  bus,
  output md_state_e        state_o
);

  localparam int CNT_W = $clog2(MAX_CYCLES);

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
  logic            owner_q, owner_d;
  logic            err_q, err_d;
  logic            wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      req, gnt;
  logic            arb_update;
  logic            owner_flush, owner_rsp_ready;

  // A requester flushing itself is invisible to arbitration in the same cycle.
  assign req = {2{~RST}} & {bus.REQ1_VALID & ~bus.FLUSH1, bus.REQ0_VALID & ~bus.FLUSH0};

  rr_arbiter2 u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .req_i    (req),
    .update_i (arb_update),
    .upd_id_i (owner_q),
    .gnt_o    (gnt)
  );

  assign owner_flush     = owner_q ? bus.FLUSH1 : bus.FLUSH0;
  assign owner_rsp_ready = owner_q ? bus.RSP1_READY : bus.RSP0_READY;

  assign bus.MD_M_CNT = op_q;
  assign bus.MD_RS1   = rs1_q;
  assign bus.MD_RS2   = rs2_q;
  assign state_o      = state_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    owner_d        = owner_q;
    result_d       = result_q;
    err_d          = err_q;
    wd_d           = wd_q;
    cnt_d          = cnt_q;
    arb_update     = 1'b0;
    bus.REQ0_READY = 1'b0;
    bus.REQ1_READY = 1'b0;
    bus.RSP0_VALID = 1'b0;
    bus.RSP1_VALID = 1'b0;
    bus.RSP0_DATA  = '0;
    bus.RSP1_DATA  = '0;
    bus.RSP0_ERR   = 1'b0;
    bus.RSP1_ERR   = 1'b0;
    bus.MD_START   = 1'b0;
    bus.MD_STALL   = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          bus.REQ0_READY = gnt[0];
          bus.REQ1_READY = gnt[1];
          owner_d        = gnt[1];
          op_d           = md_op_e'(gnt[1] ? bus.REQ1_OP : bus.REQ0_OP);
          rs1_d          = gnt[1] ? bus.REQ1_RS1 : bus.REQ0_RS1;
          rs2_d          = gnt[1] ? bus.REQ1_RS2 : bus.REQ0_RS2;
          cnt_d          = '0;
          state_d        = ST_BUSY;
        end
      end

      ST_BUSY: begin
        bus.MD_START = 1'b1;
        bus.MD_STALL = 1'b0;
        // cnt_q == 0 is the launch cycle, where MD_READY still reflects the old op.
        if (owner_flush) begin
          wd_d    = 1'b0;
          state_d = ST_DRAIN;
        end else if (cnt_q != '0 && bus.MD_READY) begin
          result_d = bus.MD_OUT;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          wd_d     = 1'b1;
          state_d  = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DRAIN: begin
        wd_d    = 1'b0;
        state_d = wd_q ? ST_RESP : ST_IDLE;
      end

      ST_RESP: begin
        bus.RSP0_VALID = ~owner_q;
        bus.RSP1_VALID = owner_q;
        bus.RSP0_DATA  = owner_q ? '0 : result_q;
        bus.RSP1_DATA  = owner_q ? result_q : '0;
        bus.RSP0_ERR   = ~owner_q & err_q;
        bus.RSP1_ERR   = owner_q & err_q;
        if (owner_flush || owner_rsp_ready) begin
          arb_update = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      rs1_q    <= '0;
      rs2_q    <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      wd_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: behavioural mul/div unit with programmable latency,
// table of single ops, hand-written contention/back-pressure/flush/watchdog/reset cases.
module tb_muldiv_arbiter;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int MAXC = 40;

  logic      CLK = 1'b0;
  logic      RST = 1'b1;
  md_state_e state;

  always #5 CLK = ~CLK;

  muldiv_arbiter_if #(.XLEN(XLEN)) bus ();

  muldiv_arbiter #(.XLEN(XLEN), .MAX_CYCLES(MAXC)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .state_o (state)
  );

  int tests_run = 0;
  int failures  = 0;
  int cyc       = 0;
  int md_lat    = 0;
  int busy_cnt  = 0;
  int rsp0_cnt  = 0;
  int rsp1_cnt  = 0;
  int rsp0_cyc  = 0;
  int rsp1_cyc  = 0;
  int ready0_cnt = 0;
  int gnt_log[$];
  logic [XLEN:0] exp0_q[$];
  logic [XLEN:0] exp1_q[$];
  logic [XLEN:0] exp0_next = '0;
  logic [XLEN:0] exp1_next = '0;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp;
    int          exp_lat;
  } vec_t;
  vec_t vecs[9];

  // ---------------- clock/reset bookkeeping ----------------
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- behavioural RV32M unit ----------------
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (bus.MD_START && !bus.MD_STALL) busy_cnt <= busy_cnt + 1;
    else                               busy_cnt <= 0;
  end

  assign bus.MD_READY = bus.MD_START && !bus.MD_STALL && (md_lat != 0) && (busy_cnt >= md_lat - 1);
  assign bus.MD_OUT   = ref_md(bus.MD_M_CNT, bus.MD_RS1, bus.MD_RS2);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drv();
    @(posedge CLK); #1;
  endtask

  task automatic smp();
    @(negedge CLK); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.REQ0_READY) begin exp0_q.push_back(exp0_next); gnt_log.push_back(0); ready0_cnt++; end
      if (bus.REQ1_READY) begin exp1_q.push_back(exp1_next); gnt_log.push_back(1); end
      if (bus.RSP0_VALID) rsp0_cnt++;
      if (bus.RSP1_VALID) rsp1_cnt++;
      if (bus.RSP0_VALID && bus.RSP0_READY && !bus.FLUSH0) begin
        rsp0_cyc = cyc;
        if (exp0_q.size() == 0) begin
          tests_run++; failures++;
          $display("FAIL rsp0_unexpected: got 0x%0h, expected no response", bus.RSP0_DATA);
        end else begin
          check("rsp0_data", 64'({bus.RSP0_ERR, bus.RSP0_DATA}), 64'(exp0_q.pop_front()));
        end
      end
      if (bus.RSP1_VALID && bus.RSP1_READY && !bus.FLUSH1) begin
        rsp1_cyc = cyc;
        if (exp1_q.size() == 0) begin
          tests_run++; failures++;
          $display("FAIL rsp1_unexpected: got 0x%0h, expected no response", bus.RSP1_DATA);
        end else begin
          check("rsp1_data", 64'({bus.RSP1_ERR, bus.RSP1_DATA}), 64'(exp1_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant(input int n, output int g);
    int k;
    k = 0;
    smp();
    while (!(n == 0 ? bus.REQ0_READY : bus.REQ1_READY) && k < 20) begin smp(); k++; end
    check($sformatf("grant%0d_seen", n), 64'(n == 0 ? bus.REQ0_READY : bus.REQ1_READY), 64'd1);
    g = cyc;
  endtask

  task automatic wait_rsp_valid(input int n);
    int k;
    k = 0;
    smp();
    while (!(n == 0 ? bus.RSP0_VALID : bus.RSP1_VALID) && k < 100) begin smp(); k++; end
    check($sformatf("rsp%0d_valid_seen", n), 64'(n == 0 ? bus.RSP0_VALID : bus.RSP1_VALID), 64'd1);
  endtask

  task automatic wait_empty(input int limit);
    int k;
    k = 0;
    while ((exp0_q.size() + exp1_q.size()) != 0 && k < limit) begin smp(); k++; end
    check("scoreboard_drained", 64'(exp0_q.size() + exp1_q.size()), 64'd0);
  endtask

  task automatic check_reset(input string name);
    check(name, 64'({state, bus.REQ0_READY, bus.REQ1_READY, bus.RSP0_VALID, bus.RSP1_VALID,
                     bus.RSP0_ERR, bus.RSP1_ERR, bus.MD_START, bus.MD_STALL, bus.MD_M_CNT}),
          64'({ST_IDLE, 7'b0, 1'b1, 3'b0}));
    check({name, "_data"}, 64'({bus.RSP0_DATA, bus.RSP1_DATA}), 64'd0);
    check({name, "_md_ops"}, 64'({bus.MD_RS1, bus.MD_RS2}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish within 200000 time units");
    $fatal(1, "bench timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int g, r0, r1, bad_stable, bad_start, bad_grant;

    vecs[0] = '{OP_MUL,    32'd7,          32'd6,          33, 32'd42,         34};
    vecs[1] = '{OP_MULH,   32'hFFFF_FFFE,  32'd3,          4,  32'hFFFF_FFFF,  5};
    vecs[2] = '{OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF,  2,  32'h8000_0000,  3};
    vecs[3] = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5,  32'hFFFF_FFFE,  6};
    vecs[4] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  3,  32'h8000_0000,  4};
    vecs[5] = '{OP_DIVU,   32'd123,        32'd0,          2,  32'hFFFF_FFFF,  3};
    vecs[6] = '{OP_REM,    32'hFFFF_FFF9,  32'd2,          6,  32'hFFFF_FFFF,  7};
    vecs[7] = '{OP_REMU,   32'd100,        32'd7,          2,  32'd2,          3};
    vecs[8] = '{OP_MUL,    32'd5,          32'd5,          1,  32'd25,         3};

    bus.REQ0_VALID = 0; bus.REQ1_VALID = 0;
    bus.REQ0_OP = '0; bus.REQ1_OP = '0;
    bus.REQ0_RS1 = '0; bus.REQ0_RS2 = '0; bus.REQ1_RS1 = '0; bus.REQ1_RS2 = '0;
    bus.RSP0_READY = 1; bus.RSP1_READY = 1;
    bus.FLUSH0 = 0; bus.FLUSH1 = 0;

    repeat (3) drv();
    RST = 0;
    smp();
    check_reset("reset_state");

    // Table of single operations from requester 0.
    foreach (vecs[i]) begin
      md_lat = vecs[i].lat;
      exp0_next = {1'b0, vecs[i].exp};
      drv();
      ready0_cnt = 0;
      bus.REQ0_VALID = 1; bus.REQ0_OP = vecs[i].op;
      bus.REQ0_RS1 = vecs[i].a; bus.REQ0_RS2 = vecs[i].b;
      wait_grant(0, g);
      drv();
      bus.REQ0_VALID = 0; bus.REQ0_OP = 3'($urandom_range(0, 7));
      bus.REQ0_RS1 = $urandom; bus.REQ0_RS2 = $urandom;
      smp();
      check("md_ctl", 64'({bus.MD_START, bus.MD_STALL, bus.MD_M_CNT}), 64'({1'b1, 1'b0, vecs[i].op}));
      check("md_ops", 64'({bus.MD_RS1, bus.MD_RS2}), 64'({vecs[i].a, vecs[i].b}));
      wait_empty(100);
      check("rsp_latency", 64'(rsp0_cyc - g), 64'(vecs[i].exp_lat));
      check("req0_ready_pulse", 64'(ready0_cnt), 64'd1);
    end

    // Back-pressure on requester 1 while requester 0 waits.
    md_lat = 3;
    exp1_next = {1'b0, 32'd15};
    exp0_next = {1'b0, 32'd4};
    drv();
    bus.RSP1_READY = 0;
    bus.REQ1_VALID = 1; bus.REQ1_OP = OP_MUL; bus.REQ1_RS1 = 32'd3; bus.REQ1_RS2 = 32'd5;
    wait_grant(1, g);
    drv();
    bus.REQ1_VALID = 0;
    bus.REQ0_VALID = 1; bus.REQ0_OP = OP_MUL; bus.REQ0_RS1 = 32'd2; bus.REQ0_RS2 = 32'd2;
    wait_rsp_valid(1);
    bad_stable = 0; bad_start = 0; bad_grant = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(bus.RSP1_VALID && bus.RSP1_DATA == 32'd15 && !bus.RSP1_ERR)) bad_stable++;
      if (bus.MD_START || !bus.MD_STALL) bad_start++;
      if (bus.REQ0_READY || bus.RSP0_VALID) bad_grant++;
      smp();
    end
    check("bp_rsp_stable", 64'(bad_stable), 64'd0);
    check("bp_md_idle", 64'(bad_start), 64'd0);
    check("bp_no_grant", 64'(bad_grant), 64'd0);
    drv();
    bus.RSP1_READY = 1;
    wait_grant(0, g);
    drv();
    bus.REQ0_VALID = 0;
    wait_empty(50);

    // Owner flush in BUSY cycle 5 with requester 1 pending.
    md_lat = 0;
    exp1_next = {1'b0, 32'd2};
    r0 = rsp0_cnt;
    drv();
    bus.REQ0_VALID = 1; bus.REQ0_OP = OP_DIV; bus.REQ0_RS1 = 32'd9; bus.REQ0_RS2 = 32'd3;
    wait_grant(0, g);
    drv();
    bus.REQ0_VALID = 0;
    bus.REQ1_VALID = 1; bus.REQ1_OP = OP_REMU; bus.REQ1_RS1 = 32'd100; bus.REQ1_RS2 = 32'd7;
    while (cyc < g + 5) drv();
    bus.FLUSH0 = 1;
    smp();
    check("flush_in_busy", 64'(state), 64'(ST_BUSY));
    drv();
    bus.FLUSH0 = 0;
    md_lat = 2;
    smp();
    check("flush_drain", 64'({state, bus.MD_START, bus.MD_STALL}), 64'({ST_DRAIN, 1'b0, 1'b1}));
    exp0_q.delete();
    smp();
    check("flush_next_grant", 64'(bus.REQ1_READY), 64'd1);
    drv();
    bus.REQ1_VALID = 0;
    wait_empty(50);
    check("flush_no_rsp0", 64'(rsp0_cnt), 64'(r0));

    // Watchdog: unit never answers.
    md_lat = 0;
    exp1_next = {1'b1, 32'd0};
    drv();
    bus.REQ1_VALID = 1; bus.REQ1_OP = OP_MULHU; bus.REQ1_RS1 = 32'd77; bus.REQ1_RS2 = 32'd88;
    wait_grant(1, g);
    drv();
    bus.REQ1_VALID = 0;
    while (cyc < g + MAXC) drv();
    smp();
    check("wd_last_busy", 64'(state), 64'(ST_BUSY));
    smp();
    check("wd_drain", 64'({state, bus.MD_START, bus.MD_STALL}), 64'({ST_DRAIN, 1'b0, 1'b1}));
    wait_empty(20);
    check("wd_latency", 64'(rsp1_cyc - g), 64'(MAXC + 2));

    // Reset in the middle of BUSY.
    md_lat = 0;
    exp0_next = {1'b0, 32'd143};
    drv();
    bus.REQ0_VALID = 1; bus.REQ0_OP = OP_MUL; bus.REQ0_RS1 = 32'd11; bus.REQ0_RS2 = 32'd13;
    wait_grant(0, g);
    drv();
    bus.REQ0_VALID = 0;
    repeat (3) drv();
    RST = 1;
    drv();
    RST = 0;
    smp();
    check_reset("rst_busy");
    exp0_q.delete();
    r0 = rsp0_cnt;
    repeat (5) smp();
    check("rst_busy_no_rsp", 64'(rsp0_cnt), 64'(r0));

    // Reset while a response is held off.
    md_lat = 2;
    exp1_next = {1'b0, 32'd6};
    drv();
    bus.RSP1_READY = 0;
    bus.REQ1_VALID = 1; bus.REQ1_OP = OP_MUL; bus.REQ1_RS1 = 32'd2; bus.REQ1_RS2 = 32'd3;
    wait_grant(1, g);
    drv();
    bus.REQ1_VALID = 0;
    wait_rsp_valid(1);
    drv();
    RST = 1;
    drv();
    RST = 0;
    bus.RSP1_READY = 1;
    smp();
    check_reset("rst_resp");
    exp1_q.delete();
    r1 = rsp1_cnt;
    repeat (5) smp();
    check("rst_resp_no_rsp", 64'(rsp1_cnt), 64'(r1));

    // Contention right after reset: requester 0 first, then alternating.
    md_lat = 3;
    exp0_next = {1'b0, 32'd14};
    exp1_next = {1'b0, 32'd2};
    gnt_log.delete();
    drv();
    bus.REQ0_VALID = 1; bus.REQ0_OP = OP_DIV; bus.REQ0_RS1 = 32'd100; bus.REQ0_RS2 = 32'd7;
    bus.REQ1_VALID = 1; bus.REQ1_OP = OP_REM; bus.REQ1_RS1 = 32'd100; bus.REQ1_RS2 = 32'd7;
    for (int k = 0; k < 100 && gnt_log.size() < 4; k++) smp();
    drv();
    bus.REQ0_VALID = 0; bus.REQ1_VALID = 0;
    wait_empty(50);
    check("cont_grant_count", 64'(gnt_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) check($sformatf("cont_grant%0d", i), 64'(gnt_log[i]), 64'(i % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
